if_fetch_unit: RTL

//   Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.

---
 rtl/if_fetch_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage with credit-limited imem requests and a small output FIFO
//
// Purpose:
//   Holds the fetch PC and issues in-order requests to instruction memory over a
//   req/gnt/rvalid handshake. Returned words are buffered in a BUF_DEPTH-entry FIFO
//   and presented to the IF/ID register as {instruction, PC+4}. A redirect flushes
//   the FIFO and discards every word still in flight.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   stall              ID cannot accept this cycle: hold outputs, no pop
//   redirect_valid     taken branch/jump this cycle
//   redirect_pc        redirect target (word aligned)
//   imem_req           fetch request valid
//   imem_addr          fetch address
//   imem_gnt           request accepted this cycle
//   imem_rvalid        in-order response valid
//   imem_rdata         response word
//   instruction        head word to IF/ID (0 when if_valid=0)
//   instru_addr_plus4  PC of head word + 4 (0 when if_valid=0)
//   if_valid           instruction/instru_addr_plus4 are valid

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instru_addr_plus4,
    output logic        if_valid
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      buf_word [BUF_DEPTH];
    logic [31:0]      buf_pc   [BUF_DEPTH];

    logic [CNT_W:0]   credit_sum;
    logic             issue;
    logic             resp;
    logic             drop;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] in_flight_after;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Every word either sits in the FIFO or is still in flight, so the sum of
    // the two bounds FIFO occupancy: a granted request always has a slot.
    always_comb begin
        credit_sum = {1'b0, outstanding} + {1'b0, count};
        imem_req   = !rst && !redirect_valid && (credit_sum < DEPTH_EXT);
        imem_addr  = fetch_pc;
        issue      = imem_req && imem_gnt;

        // A response with nothing in flight is a protocol error and is ignored.
        resp       = imem_rvalid && (outstanding != '0);
        drop       = resp && (drop_cnt != '0);
        push       = resp && !drop && !redirect_valid;

        if_valid          = !rst && (count != '0);
        pop               = if_valid && !stall && !redirect_valid;
        instruction       = if_valid ? buf_word[rd_ptr] : 32'h0;
        instru_addr_plus4 = if_valid ? (buf_pc[rd_ptr] + 32'd4) : 32'h0;

        in_flight_after   = outstanding - CNT_W'(resp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // Every request still in flight after this cycle belongs to the old
            // path, including any already marked for dropping, so the drop count
            // is simply what remains outstanding. The rvalid word of this cycle
            // is consumed and discarded here.
            fetch_pc    <= redirect_pc;
            resp_pc     <= redirect_pc;
            outstanding <= in_flight_after;
            drop_cnt    <= in_flight_after;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(resp);
            if (drop) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                wr_ptr  <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // FIFO storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            buf_word[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= resp_pc;
        end
    end

endmodule
